// File: rtl/reg_bank_wr_pkg.sv
// Shared constants for the register bank: write-enable bit positions, read-select codes,
// and the read-code to register-slot decode used by the read mux.
package reg_bank_wr_pkg;

  localparam int unsigned NUM_REGS = 20;

  // Bit position of each register's enable in the one-hot write vector.
  typedef enum logic [4:0] {
    IDX_IR   = 5'd0,
    IDX_AR   = 5'd1,
    IDX_TR   = 5'd2,
    IDX_MDDR = 5'd3,
    IDX_TOTR = 5'd4,
    IDX_PC   = 5'd5,
    IDX_R14  = 5'd6,
    IDX_R1   = 5'd19
  } wr_idx_e;

  typedef enum logic [4:0] {
    CODE_NONE = 5'd0,
    CODE_R1   = 5'd1,
    CODE_R14  = 5'd14,
    CODE_PC   = 5'd15,
    CODE_TOTR = 5'd16,
    CODE_MDDR = 5'd17,
    CODE_TR   = 5'd18,
    CODE_AR   = 5'd21,
    CODE_IR   = 5'd22,
    CODE_ALL  = 5'd31
  } rd_code_e;

  typedef struct packed {
    logic       hit;
    logic [4:0] idx;
  } rd_map_t;

  // Codes R1..TR walk the enable vector downward from bit 19; AR and IR sit apart.
  function automatic rd_map_t code_to_idx(input logic [4:0] code);
    rd_map_t map;
    map.hit = 1'b1;
    map.idx = '0;
    case (code) inside
      [CODE_R1:CODE_TR]: map.idx = 5'(int'(IDX_R1) + int'(CODE_R1) - int'(code));
      CODE_AR:           map.idx = IDX_AR;
      CODE_IR:           map.idx = IDX_IR;
      default:           map.hit = 1'b0;
    endcase
    return map;
  endfunction

endpackage

// File: rtl/reg_bank_rdmux.sv
// Combinational read-select mux: picks the register addressed by rd_sel, zero for unmapped codes.
module reg_bank_rdmux
  import reg_bank_wr_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [4:0]                           rd_sel,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]      regs,
  output logic [DATA_W-1:0]                    rd_data
);

  rd_map_t map;

  always_comb begin
    map     = code_to_idx(rd_sel);
    rd_data = '0;
    if (map.hit) begin
      rd_data = regs[map.idx];
    end
  end

endmodule

// File: rtl/reg_bank_wr.sv
// Register bank fed by the one-hot write decoder, with PC/AR auto-increment and registered
// read-back. Define REG_BANK_ONEHOT_CHECK_EN to reject multi-hot writes and flag them sticky.
module reg_bank_wr
  import reg_bank_wr_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [19:0]         WRDec_out,
  input  logic [DATA_W-1:0]   Bus_in,
  input  logic                PC_inc,
  input  logic                AR_inc,
  input  logic [4:0]          RDSel,
  output logic [DATA_W-1:0]   Bus_out,
  output logic [DATA_W-1:0]   PC_out,
  output logic [DATA_W-1:0]   AR_out,
  output logic [DATA_W-1:0]   IR_out,
  output logic [4:0]          TR_out,
  output logic                Wr_err
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             wr_en;
  logic [DATA_W-1:0]               rd_data;
  logic [DATA_W-1:0]               bus_out_q;

`ifdef REG_BANK_ONEHOT_CHECK_EN
  logic wr_legal;
  logic err_q;

  // Broadcast (all-ones) is the only legal multi-hot pattern.
  assign wr_legal = (&WRDec_out) || $onehot0(WRDec_out);
  assign wr_en    = wr_legal ? WRDec_out : '0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else if (!wr_legal) begin
      err_q <= 1'b1;
    end
  end

  assign Wr_err = err_q;
`else
  assign wr_en  = WRDec_out;
  assign Wr_err = 1'b0;
`endif

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en[i]) begin
        regs_d[i] = Bus_in;
      end
    end
    // A write to PC/AR in the same cycle takes precedence over its increment.
    if (PC_inc && !wr_en[IDX_PC]) begin
      regs_d[IDX_PC] = regs_q[IDX_PC] + DATA_W'(1);
    end
    if (AR_inc && !wr_en[IDX_AR]) begin
      regs_d[IDX_AR] = regs_q[IDX_AR] + DATA_W'(1);
    end
  end

  reg_bank_rdmux #(
    .DATA_W (DATA_W)
  ) u_rdmux (
    .rd_sel  (RDSel),
    .regs    (regs_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      regs_q         <= '0;
      regs_q[IDX_PC] <= PC_RESET;
      bus_out_q      <= '0;
    end else begin
      regs_q    <= regs_d;
      bus_out_q <= rd_data;
    end
  end

  assign Bus_out = bus_out_q;
  assign PC_out  = regs_q[IDX_PC];
  assign AR_out  = regs_q[IDX_AR];
  assign IR_out  = regs_q[IDX_IR];
  assign TR_out  = regs_q[IDX_TR][4:0];

endmodule

// File: tb/tb_reg_bank_wr.sv
// Self-checking bench for reg_bank_wr: directed scenarios plus random traffic against a
// register-file model addressed by read code.
module tb_reg_bank_wr;

  localparam logic [15:0] PCR = 16'h0010;

`ifdef REG_BANK_ONEHOT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic [19:0] WRDec_out;
  logic [15:0] Bus_in;
  logic        PC_inc, AR_inc;
  logic [4:0]  RDSel;
  logic [15:0] Bus_out, PC_out, AR_out, IR_out;
  logic [4:0]  TR_out;
  logic        Wr_err;

  reg_bank_wr #(
    .DATA_W   (16),
    .PC_RESET (PCR)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .WRDec_out (WRDec_out),
    .Bus_in    (Bus_in),
    .PC_inc    (PC_inc),
    .AR_inc    (AR_inc),
    .RDSel     (RDSel),
    .Bus_out   (Bus_out),
    .PC_out    (PC_out),
    .AR_out    (AR_out),
    .IR_out    (IR_out),
    .TR_out    (TR_out),
    .Wr_err    (Wr_err)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Model: register contents indexed by read code (unmapped codes stay 0 forever).
  logic [15:0] mreg [32];
  logic [15:0] m_bus;
  logic        m_err;
  // Read code of the register behind each enable bit (bit 0 = IR ... bit 19 = R1).
  int code_of_bit [20] = '{22, 21, 18, 17, 16, 15, 14, 13, 12, 11,
                           10, 9, 8, 7, 6, 5, 4, 3, 2, 1};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (mreg[i]) mreg[i] = '0;
    mreg[15] = PCR;
    m_bus    = '0;
    m_err    = 1'b0;
  endtask

  task automatic model_edge(input logic [19:0] en, input logic [15:0] bus,
                            input logic pci, input logic ari, input logic [4:0] sel);
    logic [15:0] nxt [32];
    nxt   = mreg;
    m_bus = mreg[sel];
    if (CHECK_EN && !(en == 20'hFFFFF || $countones(en) <= 1)) begin
      en    = '0;
      m_err = 1'b1;
    end
    for (int b = 0; b < 20; b++) begin
      if (en[b]) nxt[code_of_bit[b]] = bus;
    end
    if (pci && !en[5]) nxt[15] = mreg[15] + 16'd1;
    if (ari && !en[1]) nxt[21] = mreg[21] + 16'd1;
    mreg = nxt;
  endtask

  always @(negedge Clock) begin
    if (cmp_en) begin
      chk("bus_out", Bus_out, m_bus);
      chk("pc_out", PC_out, mreg[15]);
      chk("ar_out", AR_out, mreg[21]);
      chk("ir_out", IR_out, mreg[22]);
      chk("tr_out", TR_out, mreg[18][4:0]);
      chk("wr_err", Wr_err, m_err);
    end
  end

  // Inputs change 1 time unit after a rising edge and are sampled at the next one.
  task automatic cycle(input logic [19:0] en, input logic [15:0] bus,
                       input logic pci, input logic ari, input logic [4:0] sel);
    WRDec_out = en;
    Bus_in    = bus;
    PC_inc    = pci;
    AR_inc    = ari;
    RDSel     = sel;
    @(posedge Clock);
    model_edge(en, bus, pci, ari, sel);
    #1;
  endtask

  task automatic pulse_reset();
    #1 Reset = 1'b1;
    #1 model_reset();
    chk("async_pc", PC_out, PCR);
    chk("async_ar", AR_out, 16'h0000);
    chk("async_ir", IR_out, 16'h0000);
    chk("async_tr", TR_out, 5'h00);
    chk("async_bus", Bus_out, 16'h0000);
    chk("async_err", Wr_err, 1'b0);
    #1 Reset = 1'b0;
  endtask

  task automatic reset_across_edge(input logic [19:0] en, input logic [15:0] bus);
    WRDec_out = en;
    Bus_in    = bus;
    PC_inc    = 1'b1;
    AR_inc    = 1'b1;
    RDSel     = 5'd15;
    Reset     = 1'b1;
    #1 model_reset();
    @(posedge Clock);
    #1 Reset = 1'b0;
  endtask

  initial begin
    int codes [21] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18,
                       21, 22, 19};
    Reset = 1'b1;
    WRDec_out = '0; Bus_in = '0; PC_inc = 1'b0; AR_inc = 1'b0; RDSel = '0;
    model_reset();
    cmp_en = 1'b1;
    @(posedge Clock);
    #1 Reset = 1'b0;

    // Single write / read-back
    cycle(20'h80000, 16'h1234, 0, 0, 5'd0);
    cycle(20'h00000, 16'h0000, 0, 0, 5'd1);
    chk("r1_read", Bus_out, 16'h1234);
    cycle(20'h00001, 16'h5A5A, 0, 0, 5'd0);
    chk("ir_write", IR_out, 16'h5A5A);

    // PC wrap and write-over-increment priority
    cycle(20'h00020, 16'hFFFF, 0, 0, 5'd0);
    chk("pc_ffff", PC_out, 16'hFFFF);
    cycle(20'h00000, 16'h0000, 1, 0, 5'd0);
    chk("pc_wrap", PC_out, 16'h0000);
    cycle(20'h00020, 16'h0100, 1, 0, 5'd0);
    chk("pc_wr_prio", PC_out, 16'h0100);
    cycle(20'h00002, 16'hFFFF, 0, 0, 5'd0);
    cycle(20'h00000, 16'h0000, 1, 1, 5'd0);
    chk("ar_wrap", AR_out, 16'h0000);
    chk("pc_inc", PC_out, 16'h0101);

    pulse_reset();

    // Broadcast and read sweep
    cycle(20'hFFFFF, 16'h00A5, 0, 0, 5'd0);
    chk("bcast_tr", TR_out, 5'h05);
    foreach (codes[i]) begin
      cycle(20'h00000, 16'h0000, 0, 0, 5'(codes[i]));
      chk("sweep", Bus_out, (codes[i] == 19) ? 16'h0000 : 16'h00A5);
    end

    // Read returns the pre-edge value
    cycle(20'h20000, 16'h0001, 0, 0, 5'd0);
    cycle(20'h20000, 16'h0002, 0, 0, 5'd3);
    chk("r3_old", Bus_out, 16'h0001);
    cycle(20'h00000, 16'h0000, 0, 0, 5'd3);
    chk("r3_new", Bus_out, 16'h0002);

    // Multi-hot write: suppressed and flagged only when the checker is built
    cycle(20'h80001, 16'hBEEF, 0, 0, 5'd0);
    chk("multi_ir", IR_out, CHECK_EN ? 16'h00A5 : 16'hBEEF);
    chk("multi_err", Wr_err, CHECK_EN);
    cycle(20'h00001, 16'h1111, 0, 0, 5'd0);
    chk("err_sticky", Wr_err, CHECK_EN);

    // Reset held across an edge aborts the write and increments
    reset_across_edge(20'hFFFFF, 16'h7777);
    chk("rst_abort_pc", PC_out, PCR);
    chk("rst_abort_ir", IR_out, 16'h0000);
    chk("rst_err", Wr_err, 1'b0);

    repeat (400) begin
      logic [19:0] en;
      logic [15:0] bus;
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 3)       en = '0;
      else if (r < 7)  en = 20'(1) << $urandom_range(0, 19);
      else if (r == 7) en = 20'hFFFFF;
      else             en = 20'($urandom);
      bus = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      if ($urandom_range(0, 49) == 0) pulse_reset();
      else cycle(en, bus, 1'($urandom), 1'($urandom), 5'($urandom));
    end

    @(negedge Clock);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
